// File: rtl/missionary_cannibal_solver.sv
// Free-running solver for the 3-missionary / 3-cannibal river crossing with a boat of two.
// It keeps the left-bank counts and the boat side, and takes one safe crossing per clock.
module missionary_cannibal_solver (
   input  logic       clock,
   input  logic       reset,
   output logic [1:0] missionary_next,
   output logic [1:0] cannibal_next,
   output logic       finish
);

   logic [1:0] missionary_curr;
   logic [1:0] cannibal_curr;
   logic       direction;
   logic       direction_next;

   // Crossing table keyed on (M, C, boat side). Any key not in the table restarts the puzzle.
   always_comb begin
      missionary_next = 2'd3;
      cannibal_next   = 2'd3;
      direction_next  = 1'b0;
      case ({missionary_curr, cannibal_curr, direction})
         5'b11_11_0: begin missionary_next = 2'd3; cannibal_next = 2'd1; direction_next = 1'b1; end
         5'b11_01_1: begin missionary_next = 2'd3; cannibal_next = 2'd2; direction_next = 1'b0; end
         5'b11_10_0: begin missionary_next = 2'd3; cannibal_next = 2'd0; direction_next = 1'b1; end
         5'b11_00_1: begin missionary_next = 2'd3; cannibal_next = 2'd1; direction_next = 1'b0; end
         5'b11_01_0: begin missionary_next = 2'd1; cannibal_next = 2'd1; direction_next = 1'b1; end
         5'b01_01_1: begin missionary_next = 2'd2; cannibal_next = 2'd2; direction_next = 1'b0; end
         5'b10_10_0: begin missionary_next = 2'd0; cannibal_next = 2'd2; direction_next = 1'b1; end
         5'b00_10_1: begin missionary_next = 2'd0; cannibal_next = 2'd3; direction_next = 1'b0; end
         5'b00_11_0: begin missionary_next = 2'd0; cannibal_next = 2'd1; direction_next = 1'b1; end
         5'b00_01_1: begin missionary_next = 2'd0; cannibal_next = 2'd2; direction_next = 1'b0; end
         5'b00_10_0: begin missionary_next = 2'd0; cannibal_next = 2'd0; direction_next = 1'b1; end
         // Everyone is across: hold here with the boat on the right bank.
         5'b00_00_1: begin missionary_next = 2'd0; cannibal_next = 2'd0; direction_next = 1'b1; end
         default:    begin missionary_next = 2'd3; cannibal_next = 2'd3; direction_next = 1'b0; end
      endcase
   end

   // Puzzle state register; reset puts everyone back on the left bank with the boat.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         missionary_curr <= 2'd3;
         cannibal_curr   <= 2'd3;
         direction       <= 1'b0;
      end else begin
         missionary_curr <= missionary_next;
         cannibal_curr   <= cannibal_next;
         direction       <= direction_next;
      end
   end

   assign finish = (missionary_curr == 2'd0) && (cannibal_curr == 2'd0) && (direction == 1'b1);

endmodule

// File: tb/tb_missionary_cannibal_solver.sv
// Directed bench for missionary_cannibal_solver: reset hold, full solution, hold after
// finish, mid-sequence reset, and recovery from an illegal state.
module tb_missionary_cannibal_solver;

   logic       clock;
   logic       reset;
   logic [1:0] missionary_next;
   logic [1:0] cannibal_next;
   logic       finish;

   int checks_total;
   int checks_passed;

   // Expected (M, C) after each of the 11 crossings.
   int exp_m [11] = '{3, 3, 3, 1, 2, 0, 0, 0, 0, 0, 0};
   int exp_c [11] = '{2, 0, 1, 1, 2, 2, 3, 1, 2, 0, 0};

   missionary_cannibal_solver dut (
      .clock           (clock),
      .reset           (reset),
      .missionary_next (missionary_next),
      .cannibal_next   (cannibal_next),
      .finish          (finish)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input int observed, input int expected);
      checks_total++;
      if (observed == expected) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int bank_safe(input int m, input int c);
      return ((m == 0) || (m >= c)) ? 1 : 0;
   endfunction

   function automatic int abs_diff(input int a, input int b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // Property checks on the crossing currently presented by the DUT.
   task automatic check_crossing(input string tag);
      int m, c, mn, cn, d;
      m  = int'(dut.missionary_curr);
      c  = int'(dut.cannibal_curr);
      mn = int'(missionary_next);
      cn = int'(cannibal_next);
      check({tag, "_safe"}, bank_safe(mn, cn) & bank_safe(3 - mn, 3 - cn), 1);
      if (finish == 1'b0) begin
         d = abs_diff(m, mn) + abs_diff(c, cn);
         check({tag, "_boatload"}, ((d >= 1) && (d <= 2)) ? 1 : 0, 1);
         if (dut.direction == 1'b0) check({tag, "_dir_lr"}, ((mn <= m) && (cn <= c)) ? 1 : 0, 1);
         else                       check({tag, "_dir_rl"}, ((mn >= m) && (cn >= c)) ? 1 : 0, 1);
      end else begin
         check({tag, "_hold"}, mn * 4 + cn, 0);
      end
   endtask

   task automatic run_sequence(input string tag);
      for (int k = 0; k < 11; k++) begin
         @(posedge clock);
         @(negedge clock);
         check($sformatf("%s_m%0d", tag, k + 1), int'(missionary_next), exp_m[k]);
         check($sformatf("%s_c%0d", tag, k + 1), int'(cannibal_next), exp_c[k]);
         check($sformatf("%s_fin%0d", tag, k + 1), int'(finish), (k == 10) ? 1 : 0);
         check_crossing($sformatf("%s_x%0d", tag, k + 1));
      end
      check({tag, "_dir_end"}, int'(dut.direction), 1);
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      reset = 1'b0;

      // Reset held across several edges.
      #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("rst_m", int'(missionary_next), 3);
         check("rst_c", int'(cannibal_next), 1);
         check("rst_fin", int'(finish), 0);
         check("rst_curr", int'({dut.missionary_curr, dut.cannibal_curr, dut.direction}), 5'b11_11_0);
      end

      // Full solution, then 20 hold cycles.
      reset = 1'b1;
      run_sequence("seq1");
      for (int i = 0; i < 20; i++) begin
         @(posedge clock);
         @(negedge clock);
         check("hold_fin", int'(finish), 1);
         check("hold_next", int'({missionary_next, cannibal_next}), 0);
         check("hold_curr", int'({dut.missionary_curr, dut.cannibal_curr, dut.direction}), 5'b00_00_1);
      end

      // Restart, go five crossings, then reset asynchronously mid-cycle.
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) @(posedge clock);
      @(negedge clock);
      check("mid_m", int'(missionary_next), 2);
      check("mid_c", int'(cannibal_next), 2);
      #2;
      reset = 1'b0;
      #1;
      check("async_m", int'(missionary_next), 3);
      check("async_c", int'(cannibal_next), 1);
      check("async_fin", int'(finish), 0);
      check("async_curr", int'({dut.missionary_curr, dut.cannibal_curr, dut.direction}), 5'b11_11_0);
      @(negedge clock);
      reset = 1'b1;
      run_sequence("seq2");

      // Illegal state (2,0,0) must steer back to the start.
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      force dut.missionary_curr = 2'd2;
      force dut.cannibal_curr   = 2'd0;
      force dut.direction       = 1'b0;
      #1;
      check("ill_m", int'(missionary_next), 3);
      check("ill_c", int'(cannibal_next), 3);
      check("ill_fin", int'(finish), 0);
      #2;
      release dut.missionary_curr;
      release dut.cannibal_curr;
      release dut.direction;
      @(posedge clock);
      @(negedge clock);
      check("rec_dir", int'(dut.direction), 0);
      check("rec_m", int'(missionary_next), 3);
      check("rec_c", int'(cannibal_next), 1);
      run_sequence("seq3");

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
